// File: rtl/sensor_request_scheduler_if.sv
// Requester and sensor-side signal bundle for the sensor request scheduler.
// The slave modport is the scheduler; master is the surrounding system.
interface sensor_request_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_command;
  logic [8*NUM_REQ-1:0] req_address;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [7:0]           resp_command;
  logic [7:0]           resp_value;
  logic                 sensor_enable;
  logic [7:0]           sensor_command;
  logic [7:0]           sensor_address;
  logic                 sensor_done;
  logic [7:0]           sensor_resp_command;
  logic [7:0]           sensor_resp_value;
  logic                 busy;

  modport slave (
    input  req_valid, req_command, req_address,
    input  sensor_done, sensor_resp_command,
    input  sensor_resp_value,
    output req_ready, resp_valid,
    output resp_command, resp_value,
    output sensor_enable, sensor_command,
    output sensor_address, busy
  );

  modport master (
    output req_valid, req_command, req_address,
    output sensor_done, sensor_resp_command,
    output sensor_resp_value,
    input  req_ready, resp_valid,
    input  resp_command, resp_value,
    input  sensor_enable, sensor_command,
    input  sensor_address, busy
  );
endinterface

// File: rtl/sensor_request_scheduler.sv
// Round-robin scheduler sharing one sensor path between NUM_REQ requesters,
// with completion timeout and a minimum hold-off between transactions.
module sensor_request_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MIN_INTERVAL = 100000000,
  parameter int TIMEOUT      = 150000000,
  parameter int CNT_W        = 28
) (
  input logic clock,
  input logic reset,
  sensor_request_scheduler_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IV_LAST = CNT_W'(MIN_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       ERR_CODE = 8'h1F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    RESPOND,
    HOLDOFF
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_last;
  logic [CNT_W-1:0]   r_tcnt;
  logic [CNT_W-1:0]   r_icnt;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [7:0]         r_resp_cmd;
  logic [7:0]         r_resp_val;
  logic               r_en;
  logic [7:0]         r_cmd;
  logic [7:0]         r_addr;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_idx;
  logic [7:0]         w_cmd;
  logic [7:0]         w_addr;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_last_oh;
  int                 w_j;

  // Scan from farthest to nearest so the closest set bit after r_last wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_j     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_j = int'(r_last) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      w_idx = IW'(w_j);
      if (bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_cmd  = '0;
    w_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == w_win) begin
        w_cmd  = bus.req_command[i*8 +: 8];
        w_addr = bus.req_address[i*8 +: 8];
      end
    end
  end

  assign w_win_oh  = NUM_REQ'(1) << w_win;
  assign w_last_oh = NUM_REQ'(1) << r_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last       <= IW'(NUM_REQ - 1);
      r_tcnt       <= '0;
      r_icnt       <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_cmd   <= '0;
      r_resp_val   <= '0;
      r_en         <= 1'b0;
      r_cmd        <= '0;
      r_addr       <= '0;
    end else begin
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_found && !bus.sensor_done) begin
            r_cmd       <= w_cmd;
            r_addr      <= w_addr;
            r_en        <= 1'b1;
            r_req_ready <= w_win_oh;
            r_last      <= w_win;
            r_tcnt      <= '0;
            r_state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (r_tcnt != CNT_MAX) r_tcnt <= r_tcnt + 1'b1;
          if (bus.sensor_done) begin
            r_resp_cmd   <= bus.sensor_resp_command;
            r_resp_val   <= bus.sensor_resp_value;
            r_resp_valid <= w_last_oh;
            r_en         <= 1'b0;
            r_icnt       <= '0;
            r_state      <= RESPOND;
          end else if (r_tcnt >= TO_LAST) begin
            r_resp_cmd   <= ERR_CODE;
            r_resp_val   <= ERR_CODE;
            r_resp_valid <= w_last_oh;
            r_en         <= 1'b0;
            r_icnt       <= '0;
            r_state      <= RESPOND;
          end
        end
        RESPOND: begin
          if (r_icnt != CNT_MAX) r_icnt <= r_icnt + 1'b1;
          r_state <= HOLDOFF;
        end
        HOLDOFF: begin
          // >= keeps the exit reachable after saturation under a stuck done.
          if (r_icnt >= IV_LAST && !bus.sensor_done) begin
            r_state <= IDLE;
          end else if (r_icnt != CNT_MAX) begin
            r_icnt <= r_icnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_command   = r_resp_cmd;
  assign bus.resp_value     = r_resp_val;
  assign bus.sensor_enable  = r_en;
  assign bus.sensor_command = r_cmd;
  assign bus.sensor_address = r_addr;
  assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Directed bench for sensor_request_scheduler with MIN_INTERVAL=20,
// TIMEOUT=50, NUM_REQ=4.
module tb_sensor_request_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  sensor_request_scheduler_if #(.NUM_REQ(4)) bus ();

  sensor_request_scheduler #(
    .NUM_REQ     (4),
    .MIN_INTERVAL(20),
    .TIMEOUT     (50),
    .CNT_W       (8)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_ready == 4'b0 && n < 200);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.resp_valid == 4'b0 && n < 200);
  endtask

  int         n;
  logic       flag;
  logic [3:0] rdy;
  int         order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req_valid           = '0;
    bus.req_command         = '0;
    bus.req_address         = '0;
    bus.sensor_done         = 1'b0;
    bus.sensor_resp_command = '0;
    bus.sensor_resp_value   = '0;

    // reset state
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_enable", 32'(bus.sensor_enable), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_scmd", 32'(bus.sensor_command), 0);
    chk("rst_rcmd", 32'(bus.resp_command), 0);

    // single request
    rst_n = 1'b1;
    bus.req_valid   = 4'b0001;
    bus.req_command = 32'h0000_0001;
    bus.req_address = 32'h0000_0000;
    tick();
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_enable", 32'(bus.sensor_enable), 1);
    chk("t1_scmd", 32'(bus.sensor_command), 32'h01);
    chk("t1_busy", 32'(bus.busy), 1);
    bus.req_valid = 4'b0000;
    tick();
    chk("t1_ready_pulse", 32'(bus.req_ready), 0);
    tick();
    tick();
    tick();
    bus.sensor_done         = 1'b1;
    bus.sensor_resp_command = 8'h09;
    bus.sensor_resp_value   = 8'h1A;
    tick();
    chk("t1_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("t1_rcmd", 32'(bus.resp_command), 32'h09);
    chk("t1_rval", 32'(bus.resp_value), 32'h1A);
    chk("t1_enable_off", 32'(bus.sensor_enable), 0);
    bus.sensor_done = 1'b0;
    tick();
    chk("t1_resp_pulse", 32'(bus.resp_valid), 0);
    chk("t1_rcmd_hold", 32'(bus.resp_command), 32'h09);
    chk("t1_busy_hold", 32'(bus.busy), 1);

    // simultaneous requests 0 and 2
    rst_n = 1'b0;
    #1;
    chk("t2_rst_busy", 32'(bus.busy), 0);
    tick();
    rst_n = 1'b1;
    bus.req_valid   = 4'b0101;
    bus.req_command = 32'h0030_0010;
    bus.req_address = 32'h00A2_00A0;
    tick();
    chk("t2_ready0", 32'(bus.req_ready), 32'h1);
    chk("t2_scmd0", 32'(bus.sensor_command), 32'h10);
    chk("t2_saddr0", 32'(bus.sensor_address), 32'hA0);
    bus.req_valid = 4'b0100;
    tick();
    bus.sensor_done         = 1'b1;
    bus.sensor_resp_command = 8'h55;
    bus.sensor_resp_value   = 8'h66;
    tick();
    chk("t2_resp0", 32'(bus.resp_valid), 32'h1);
    chk("t2_rcmd0", 32'(bus.resp_command), 32'h55);
    bus.sensor_done = 1'b0;
    n = 0;
    flag = 1'b1;
    do begin
      tick();
      n++;
      if (n < 20 && !bus.busy) flag = 1'b0;
    end while (!bus.sensor_enable && n < 200);
    chk("t2_gap", 32'(n), 21);
    chk("t2_busy_holdoff", 32'(flag), 1);
    chk("t2_ready2", 32'(bus.req_ready), 32'h4);
    chk("t2_scmd2", 32'(bus.sensor_command), 32'h30);
    chk("t2_saddr2", 32'(bus.sensor_address), 32'hA2);
    bus.req_valid = 4'b0000;
    bus.sensor_done         = 1'b1;
    bus.sensor_resp_command = 8'h77;
    tick();
    chk("t2_resp2", 32'(bus.resp_valid), 32'h4);
    bus.sensor_done = 1'b0;

    // fairness with requester 0 re-raised
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid   = 4'b1111;
    bus.req_command = 32'h4342_4140;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      chk($sformatf("t3_gap%0d", k), 32'(n), (k == 0) ? 1 : 21);
      chk($sformatf("t3_ready%0d", k),
          32'(bus.req_ready), 32'(1) << order[k]);
      chk($sformatf("t3_scmd%0d", k),
          32'(bus.sensor_command), 32'h40 + order[k]);
      rdy = bus.req_ready;
      bus.req_valid = bus.req_valid & ~rdy;
      tick();
      bus.sensor_done         = 1'b1;
      bus.sensor_resp_command = 8'(8'h80 + k);
      tick();
      chk($sformatf("t3_resp%0d", k),
          32'(bus.resp_valid), 32'(1) << order[k]);
      bus.sensor_done = 1'b0;
      if (k == 0) bus.req_valid[0] = 1'b1;
    end

    // timeout on requester 1
    bus.req_valid = 4'b0010;
    wait_grant(n);
    chk("t4_gap", 32'(n), 21);
    chk("t4_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid = 4'b0000;
    wait_resp(n);
    chk("t4_cycles", 32'(n), 50);
    chk("t4_resp", 32'(bus.resp_valid), 32'h2);
    chk("t4_rcmd", 32'(bus.resp_command), 32'h1F);
    chk("t4_rval", 32'(bus.resp_value), 32'h1F);
    chk("t4_enable", 32'(bus.sensor_enable), 0);

    // reset during WAIT_DONE
    bus.req_valid   = 4'b1000;
    bus.req_command = 32'hC300_0000;
    wait_grant(n);
    chk("t5_ready", 32'(bus.req_ready), 32'h8);
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_enable", 32'(bus.sensor_enable), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_scmd", 32'(bus.sensor_command), 0);
    chk("t5_rst_rcmd", 32'(bus.resp_command), 0);
    flag = 1'b1;
    tick();
    if (bus.resp_valid != 4'b0) flag = 1'b0;
    tick();
    if (bus.resp_valid != 4'b0) flag = 1'b0;
    rst_n = 1'b1;
    bus.req_valid   = 4'b0100;
    bus.req_command = 32'h0025_0000;
    tick();
    if (bus.resp_valid != 4'b0) flag = 1'b0;
    chk("t5_no_resp", 32'(flag), 1);
    chk("t5_ready2", 32'(bus.req_ready), 32'h4);
    chk("t5_enable", 32'(bus.sensor_enable), 1);
    chk("t5_scmd", 32'(bus.sensor_command), 32'h25);
    bus.req_valid = 4'b0000;

    // sensor_done stuck high after completion
    bus.sensor_done         = 1'b1;
    bus.sensor_resp_command = 8'hAB;
    tick();
    chk("t6_resp", 32'(bus.resp_valid), 32'h4);
    chk("t6_rcmd", 32'(bus.resp_command), 32'hAB);
    bus.req_valid = 4'b0001;
    flag = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.req_ready != 4'b0 || !bus.busy) flag = 1'b0;
    end
    chk("t6_stuck_hold", 32'(flag), 1);
    bus.sensor_done = 1'b0;
    tick();
    chk("t6_idle", 32'(bus.busy), 0);
    chk("t6_no_grant_yet", 32'(bus.req_ready), 0);
    tick();
    chk("t6_grant", 32'(bus.req_ready), 32'h1);
    chk("t6_enable", 32'(bus.sensor_enable), 1);
    bus.req_valid = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
